if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined CPU. It holds the fetch PC and drives the instruction memory address. It buffers fetched {PC, instruction} pairs in a small FIFO and hands them to ID through a valid/ready handshake. Redirects (branch, jump, eret) set a new target and flush the queue in one cycle, so ID stalls no longer freeze fetch directly.

---
 rtl/if_prefetch_unit.sv | 81 ++++++++
 tb/tb_if_prefetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and drives the combinational IM.
// Fetched {pc, instr} pairs are queued and handed to ID through a valid/ready handshake.
module if_prefetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
    parameter int               DEPTH    = 4,
    parameter int               PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_en,
    input  logic                         redirect,
    input  logic [WIDTH-1:0]             redirect_pc,
    output logic [WIDTH-1:0]             imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_pc,
    output logic [31:0]                  out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [31:0]      instr;
    } entry_t;

    entry_t [DEPTH-1:0] mem;
    logic   [WIDTH-1:0] fetch_pc;
    logic   [PW-1:0]    rd_ptr;
    logic   [PW-1:0]    wr_ptr;
    logic   [WIDTH-1:0] redirect_tgt;
    logic               push;
    logic               pop;

    assign imem_addr    = fetch_pc;
    assign out_valid    = (count != '0);
    assign out_pc       = mem[rd_ptr].pc;
    assign out_instr    = mem[rd_ptr].instr;
    assign redirect_tgt = redirect_pc & ~WIDTH'(3);

    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = fetch_en & ~redirect & ((count < DEPTH_C) | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            // The head handshake (if any) is consumed by ID; everything else is dropped.
            fetch_pc <= redirect_tgt;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rdata};
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: fill, stream, redirect, wrap, drain and mid-run reset.
module tb_if_prefetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    if_prefetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .count(count)
    );

    always #5 clk = ~clk;

    // Instruction memory stand-in: each address yields a distinct word.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc ^ 32'hA5C3_0000) + 32'h0000_0101;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0; fetch_en = 1'b1;
        // cycle 0: reset state
        check("rst_addr",  imem_addr, 32'h3000);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        tick();
        // cycle 1: first entry at head
        check("c1_valid", {31'b0, out_valid}, 32'd1);
        check("c1_pc",    out_pc, 32'h3000);
        check("c1_count", {29'b0, count}, 32'd1);
        check("c1_addr",  imem_addr, 32'h3004);
        repeat (5) tick();
        // full queue, PC holds
        check("full_count", {29'b0, count}, 32'd4);
        check("full_addr",  imem_addr, 32'h3010);
        check("full_pc",    out_pc, 32'h3000);
        check("full_instr", out_instr, instr_of(32'h3000));
        tick();
        check("full_hold_addr", imem_addr, 32'h3010);

        // streaming: one pop + one push per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("stream_pc",    out_pc, 32'h3000 + 32'(4 * i));
            check("stream_instr", out_instr, instr_of(32'h3000 + 32'(4 * i)));
            check("stream_count", {29'b0, count}, 32'd4);
            tick();
        end
        check("stream_addr", imem_addr, 32'h3028);
        // single pop without fetch -> count 3
        fetch_en = 1'b0;
        tick();
        check("pre_redir_count", {29'b0, count}, 32'd3);
        check("pre_redir_pc",    out_pc, 32'h301C);

        // redirect with unaligned target; fetch_en asserted but overridden
        fetch_en = 1'b1; out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_3083;
        tick();
        redirect = 1'b0;
        check("redir_count", {29'b0, count}, 32'd0);
        check("redir_valid", {31'b0, out_valid}, 32'd0);
        check("redir_addr",  imem_addr, 32'h3080);
        tick();
        check("redir_head_valid", {31'b0, out_valid}, 32'd1);
        check("redir_head_pc",    out_pc, 32'h3080);
        check("redir_head_instr", out_instr, instr_of(32'h3080));

        // redirect to top of address space, then wrap
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap_addr0",  imem_addr, 32'hFFFF_FFFC);
        check("wrap_count0", {29'b0, count}, 32'd0);
        tick();
        check("wrap_pc0",   out_pc, 32'hFFFF_FFFC);
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        tick();
        check("wrap_pc1",    out_pc, 32'h0000_0000);
        check("wrap_instr1", out_instr, instr_of(32'h0));
        check("wrap_count1", {29'b0, count}, 32'd1);
        check("wrap_addr2",  imem_addr, 32'h0000_0004);

        // build count = 2, then drain with fetch disabled
        out_ready = 1'b0;
        tick();
        check("drain_count2", {29'b0, count}, 32'd2);
        check("drain_addr2",  imem_addr, 32'h8);
        fetch_en = 1'b0; out_ready = 1'b1;
        tick();
        check("drain_count1", {29'b0, count}, 32'd1);
        check("drain_pc1",    out_pc, 32'h4);
        check("drain_addr1",  imem_addr, 32'h8);
        tick();
        check("drain_count0", {29'b0, count}, 32'd0);
        check("drain_valid0", {31'b0, out_valid}, 32'd0);
        check("drain_addr0",  imem_addr, 32'h8);

        // refill then reset mid-stream
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        check("refill_count", {29'b0, count}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_addr",  imem_addr, 32'h3000);
        check("mid_rst_count", {29'b0, count}, 32'd0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("post_rst_pc", out_pc, 32'h3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
